// File: rtl/conv2x2_sequencer_if.sv
// Control bundle between the top-level controller and conv2x2_sequencer.
// The master drives the job request; the slave (sequencer) drives the datapath controls.
interface conv2x2_sequencer_if;
   logic       start;
   logic       abort;
   logic       win_row;
   logic       win_col;
   logic       busy;
   logic       done;
   logic       acc_clr;
   logic       sys_2by2_en;
   logic [4:0] input_array_addr_in_2by2;
   logic [4:0] filter_ceiling_first_array_addr_in_2by2;
   logic [4:0] filter_ceiling_second_array_addr_in_2by2;
   logic [1:0] buffer_read_addr_in_2by2;
   logic       out_valid;
   logic [1:0] out_idx;

   modport master (
      output start, abort, win_row, win_col,
      input  busy, done, acc_clr, sys_2by2_en,
             input_array_addr_in_2by2,
             filter_ceiling_first_array_addr_in_2by2,
             filter_ceiling_second_array_addr_in_2by2,
             buffer_read_addr_in_2by2, out_valid, out_idx
   );

   modport slave (
      input  start, abort, win_row, win_col,
      output busy, done, acc_clr, sys_2by2_en,
             input_array_addr_in_2by2,
             filter_ceiling_first_array_addr_in_2by2,
             filter_ceiling_second_array_addr_in_2by2,
             buffer_read_addr_in_2by2, out_valid, out_idx
   );
endinterface

// File: rtl/conv2x2_sequencer.sv
// Sequences one 2x2-output convolution job: clear, skewed feed, drain, buffer read, done.
// Optional CONV2X2_SEQ_PERF_EN adds job_count_o, a wrapping count of completed jobs.
module conv2x2_sequencer #(
   parameter int unsigned N_TAPS       = 9,
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned ZERO_SEL     = 25
) (
   input  logic                clk,
   input  logic                rst,
   conv2x2_sequencer_if.slave  seq
`ifdef CONV2X2_SEQ_PERF_EN
   ,
   output logic [15:0]         job_count_o
`endif
);

   localparam int unsigned SEL_W    = 5;
   localparam int unsigned RD_W     = 2;
   localparam int unsigned FILT_B   = 16;
   localparam int unsigned N_READS  = 4;
   localparam int unsigned CNT_MAX  = (N_TAPS + 1 > DRAIN_CYCLES) ? N_TAPS + 1 : DRAIN_CYCLES;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_READ,
      S_FLUSH,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               win_row_q, win_row_d;
   logic               win_col_q, win_col_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               acc_clr_q, acc_clr_d;
   logic               en_q, en_d;
   logic [SEL_W-1:0]   in_sel_q, in_sel_d;
   logic [SEL_W-1:0]   f1_sel_q, f1_sel_d;
   logic [SEL_W-1:0]   f2_sel_q, f2_sel_d;
   logic [RD_W-1:0]    rd_addr_q, rd_addr_d;
   logic               out_valid_q, out_valid_d;
   logic [RD_W-1:0]    out_idx_q, out_idx_d;

   // Input-mux select for tap k of a 3x3 filter placed at window origin (row, col).
   function automatic logic [SEL_W-1:0] tap_addr(input logic row, input logic col,
                                                  input logic [CNT_W-1:0] k);
      logic [CNT_W-1:0] r;
      logic [CNT_W-1:0] c;
      logic [SEL_W-1:0] rr;
      r  = (k >= CNT_W'(6)) ? CNT_W'(2) : ((k >= CNT_W'(3)) ? CNT_W'(1) : CNT_W'(0));
      c  = k - CNT_W'(3) * r;
      rr = SEL_W'(r) + SEL_W'(row);
      return (rr << 2) + SEL_W'(c) + SEL_W'(col);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         win_row_q   <= 1'b0;
         win_col_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         acc_clr_q   <= 1'b0;
         en_q        <= 1'b0;
         in_sel_q    <= SEL_W'(ZERO_SEL);
         f1_sel_q    <= SEL_W'(ZERO_SEL);
         f2_sel_q    <= SEL_W'(ZERO_SEL);
         rd_addr_q   <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         win_row_q   <= win_row_d;
         win_col_q   <= win_col_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         acc_clr_q   <= acc_clr_d;
         en_q        <= en_d;
         in_sel_q    <= in_sel_d;
         f1_sel_q    <= f1_sel_d;
         f2_sel_q    <= f2_sel_d;
         rd_addr_q   <= rd_addr_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
      end
   end

   // Next state, then registered outputs derived from the state being entered.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      acc_clr_d   = 1'b0;
      en_d        = 1'b0;
      in_sel_d    = SEL_W'(ZERO_SEL);
      f1_sel_d    = SEL_W'(ZERO_SEL);
      f2_sel_d    = SEL_W'(ZERO_SEL);
      rd_addr_d   = '0;
      out_valid_d = 1'b0;
      out_idx_d   = '0;

      unique case (state_q)
         S_IDLE: begin
            if (seq.start && !seq.abort) begin
               state_d   = S_CLEAR;
               cnt_d     = '0;
               win_row_d = seq.win_row;
               win_col_d = seq.win_col;
            end
         end
         S_CLEAR: begin
            state_d = S_FEED;
            cnt_d   = '0;
         end
         S_FEED: begin
            if (cnt_q == CNT_W'(N_TAPS)) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
               state_d = S_READ;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_READ: begin
            if (cnt_q == CNT_W'(N_READS - 1)) begin
               state_d = S_FLUSH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FLUSH: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (seq.abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end

      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      acc_clr_d = (state_d == S_CLEAR);
      en_d      = (state_d == S_FEED) || (state_d == S_DRAIN);

      // Second filter column trails the first by one cycle for the systolic skew.
      if (state_d == S_FEED) begin
         if (cnt_d < CNT_W'(N_TAPS)) begin
            in_sel_d = tap_addr(win_row_d, win_col_d, cnt_d);
            f1_sel_d = SEL_W'(FILT_B) + SEL_W'(cnt_d);
         end
         if (cnt_d != '0) begin
            f2_sel_d = SEL_W'(FILT_B - 1) + SEL_W'(cnt_d);
         end
      end

      if (state_d == S_READ) begin
         rd_addr_d = RD_W'(cnt_d);
      end

      // Buffer has one cycle of read latency, so tag the address issued last cycle.
      out_valid_d = (state_q == S_READ) && (state_d != S_IDLE);
      out_idx_d   = out_valid_d ? rd_addr_q : '0;
   end

   assign seq.busy                                     = busy_q;
   assign seq.done                                     = done_q;
   assign seq.acc_clr                                  = acc_clr_q;
   assign seq.sys_2by2_en                              = en_q;
   assign seq.input_array_addr_in_2by2                 = in_sel_q;
   assign seq.filter_ceiling_first_array_addr_in_2by2  = f1_sel_q;
   assign seq.filter_ceiling_second_array_addr_in_2by2 = f2_sel_q;
   assign seq.buffer_read_addr_in_2by2                 = rd_addr_q;
   assign seq.out_valid                                = out_valid_q;
   assign seq.out_idx                                  = out_idx_q;

`ifdef CONV2X2_SEQ_PERF_EN
   logic [15:0] job_count_q;

   // Counts completed jobs; aborted jobs never reach DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         job_count_q <= '0;
      end else if (state_d == S_DONE) begin
         job_count_q <= job_count_q + 16'd1;
      end
   end

   assign job_count_o = job_count_q;
`endif

endmodule

// File: tb/tb_conv2x2_sequencer.sv
// Self-checking bench for conv2x2_sequencer against a cycle-indexed job timeline model.
module tb_conv2x2_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   conv2x2_sequencer_if bus ();

`ifdef CONV2X2_SEQ_PERF_EN
   logic [15:0] job_count;
`endif

   conv2x2_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .seq         (bus)
`ifdef CONV2X2_SEQ_PERF_EN
      ,
      .job_count_o (job_count)
`endif
   );

   always #5 clk = ~clk;

   // Expected outputs in cycle t of a job (t=1 is the cycle after start is accepted; t=0 or >=20 idle).
   function automatic logic [23:0] model(input int row, input int col, input int t);
      logic       busy, done, clr, en, ov;
      logic [4:0] is, f1, f2;
      logic [1:0] rd, oi;
      int         f;
      busy = (t >= 1) && (t <= 19);
      done = (t == 19);
      clr  = (t == 1);
      en   = (t >= 2) && (t <= 13);
      is = 5'd25; f1 = 5'd25; f2 = 5'd25;
      rd = 2'd0; ov = 1'b0; oi = 2'd0;
      if (t >= 2 && t <= 11) begin
         f = t - 2;
         if (f < 9) begin
            is = 5'(4 * (row + f / 3) + col + f % 3);
            f1 = 5'(16 + f);
         end
         if (f > 0) f2 = 5'(15 + f);
      end
      if (t >= 14 && t <= 17) rd = 2'(t - 14);
      if (t >= 15 && t <= 18) begin
         ov = 1'b1;
         oi = 2'(t - 15);
      end
      return {busy, done, clr, en, is, f1, f2, rd, ov, oi};
   endfunction

   function automatic logic [23:0] obs();
      return {bus.busy, bus.done, bus.acc_clr, bus.sys_2by2_en,
              bus.input_array_addr_in_2by2,
              bus.filter_ceiling_first_array_addr_in_2by2,
              bus.filter_ceiling_second_array_addr_in_2by2,
              bus.buffer_read_addr_in_2by2, bus.out_valid, bus.out_idx};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present start with a window for one accepting edge, then scramble the window.
   task automatic launch(input int row, input int col);
      bus.win_row = 1'(row);
      bus.win_col = 1'(col);
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
      bus.win_row = ~bus.win_row;
      bus.win_col = ~bus.win_col;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.abort = 1'b0; bus.win_row = 1'b0; bus.win_col = 1'b0;
      rst = 1'b0;
      repeat (2) tick();
      checks++;
      if (obs() !== model(0, 0, 0)) begin
         $display("FAIL reset_hold got=%h exp=%h", obs(), model(0, 0, 0)); errors++;
      end
      rst = 1'b1;
      repeat (2) tick();
      checks++;
      if (obs() !== model(0, 0, 0)) begin
         $display("FAIL reset_release got=%h exp=%h", obs(), model(0, 0, 0)); errors++;
      end
   endtask

   task automatic test_window(input int row, input int col);
      launch(row, col);
      for (int t = 1; t <= 20; t++) begin
         checks++;
         if (obs() !== model(row, col, t)) begin
            $display("FAIL window r%0d c%0d t=%0d got=%h exp=%h", row, col, t, obs(), model(row, col, t));
            errors++;
         end
         if (t < 20) tick();
      end
   endtask

   // Random windows with start and window noise while busy, which must be ignored.
   task automatic test_random_jobs();
      int row, col;
      for (int n = 0; n < 6; n++) begin
         row = int'($urandom_range(1, 0));
         col = int'($urandom_range(1, 0));
         launch(row, col);
         for (int t = 1; t <= 20; t++) begin
            checks++;
            if (obs() !== model(row, col, t)) begin
               $display("FAIL random n=%0d t=%0d got=%h exp=%h", n, t, obs(), model(row, col, t));
               errors++;
            end
            if (t < 20) begin
               bus.start   = 1'($urandom_range(1, 0));
               bus.win_row = 1'($urandom_range(1, 0));
               bus.win_col = 1'($urandom_range(1, 0));
               tick();
            end
         end
         bus.start = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      int row, col;
      row = int'($urandom_range(1, 0));
      col = int'($urandom_range(1, 0));
      bus.win_row = 1'(row); bus.win_col = 1'(col);
      bus.start = 1'b1;
      tick();
      for (int j = 0; j < 3; j++) begin
         for (int t = 1; t <= 20; t++) begin
            checks++;
            if (obs() !== model(row, col, t)) begin
               $display("FAIL back_to_back j=%0d t=%0d got=%h exp=%h", j, t, obs(), model(row, col, t));
               errors++;
            end
            if (t == 20) begin
               row = int'($urandom_range(1, 0));
               col = int'($urandom_range(1, 0));
               bus.win_row = 1'(row); bus.win_col = 1'(col);
            end
            if (!(j == 2 && t == 20)) tick();
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_abort();
      int row, col, abort_at;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      checks++;
      if (obs() !== model(0, 0, 0)) begin
         $display("FAIL abort_idle got=%h exp=%h", obs(), model(0, 0, 0)); errors++;
      end
      for (int n = 0; n < 4; n++) begin
         abort_at = (n == 0) ? 8 : int'($urandom_range(18, 1));
         row = int'($urandom_range(1, 0));
         col = int'($urandom_range(1, 0));
         launch(row, col);
         for (int t = 1; t <= abort_at; t++) begin
            checks++;
            if (obs() !== model(row, col, t)) begin
               $display("FAIL abort_pre at=%0d t=%0d got=%h exp=%h", abort_at, t, obs(), model(row, col, t));
               errors++;
            end
            if (t < abort_at) tick();
         end
         bus.abort = 1'b1;
         tick();
         bus.abort = 1'b0;
         checks++;
         if (obs() !== model(0, 0, 0)) begin
            $display("FAIL abort_after at=%0d got=%h exp=%h", abort_at, obs(), model(0, 0, 0));
            errors++;
         end
         row = int'($urandom_range(1, 0));
         col = int'($urandom_range(1, 0));
         launch(row, col);
         for (int t = 1; t <= 20; t++) begin
            checks++;
            if (obs() !== model(row, col, t)) begin
               $display("FAIL abort_restart at=%0d t=%0d got=%h exp=%h", abort_at, t, obs(), model(row, col, t));
               errors++;
            end
            if (t < 20) tick();
         end
      end
   endtask

   task automatic test_reset_mid_job();
      launch(1, 0);
      for (int t = 1; t <= 5; t++) begin
         checks++;
         if (obs() !== model(1, 0, t)) begin
            $display("FAIL rst_mid_pre t=%0d got=%h exp=%h", t, obs(), model(1, 0, t)); errors++;
         end
         tick();
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (obs() !== model(0, 0, 0)) begin
         $display("FAIL rst_mid_async got=%h exp=%h", obs(), model(0, 0, 0)); errors++;
      end
      tick();
      checks++;
      if (obs() !== model(0, 0, 0)) begin
         $display("FAIL rst_mid_hold got=%h exp=%h", obs(), model(0, 0, 0)); errors++;
      end
      rst = 1'b1;
      repeat (2) tick();
      checks++;
      if (obs() !== model(0, 0, 0)) begin
         $display("FAIL rst_mid_release got=%h exp=%h", obs(), model(0, 0, 0)); errors++;
      end
      launch(0, 1);
      for (int t = 1; t <= 20; t++) begin
         checks++;
         if (obs() !== model(0, 1, t)) begin
            $display("FAIL rst_mid_job t=%0d got=%h exp=%h", t, obs(), model(0, 1, t)); errors++;
         end
         if (t < 20) tick();
      end
   endtask

`ifdef CONV2X2_SEQ_PERF_EN
   task automatic test_perf();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if (job_count !== 16'd0) begin
         $display("FAIL perf_reset got=%0d exp=0", job_count); errors++;
      end
      for (int n = 0; n < 3; n++) begin
         launch(int'($urandom_range(1, 0)), int'($urandom_range(1, 0)));
         repeat (19) tick();
         if (n == 1) begin
            launch(0, 0);
            repeat (4) tick();
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
         end
      end
      checks++;
      if (job_count !== 16'd3) begin
         $display("FAIL perf_count got=%0d exp=3", job_count); errors++;
      end
   endtask
`endif

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0; bus.win_row = 1'b0; bus.win_col = 1'b0;
      test_reset();
      test_window(0, 0);
      test_window(1, 1);
      test_window(0, 1);
      test_random_jobs();
      test_back_to_back();
      test_abort();
      test_reset_mid_job();
`ifdef CONV2X2_SEQ_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv2x2_sequencer.md
Name: conv2x2_sequencer

Overview:
- Control FSM that sequences one 2x2-output convolution job through the 2x2 convolution datapath.
- Generates the three 5-bit mux selects (input, first filter, second filter) with systolic skew, the systolic enable, an accumulator-clear pulse and the 2-bit result-buffer read address.
- Produces a start/busy/done handshake for the top-level controller.
- Mux select map: 0–15 input a00..a33 (row-major, 4*row+col); 16–24 filter b00..b22 (16+3*r+c); 25 reads zero.

Parameters:
- N_TAPS, 9, filter taps per job (3x3).
- DRAIN_CYCLES, 2, cycles the enable is held after the last feed cycle to flush the array.
- ZERO_SEL, 25, mux select that yields 8'b0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low. All state clears while rst=0.
- start  input  1  job request, sampled only in IDLE.
- abort  input  1  synchronous cancel of the current job.
- win_row  input  1  window origin row (0..1).
- win_col  input  1  window origin column (0..1).
- busy  output  1  high from the cycle after start is accepted up to and including the done cycle.
- done  output  1  one-cycle completion pulse.
- acc_clr  output  1  one-cycle systolic accumulator clear.
- sys_2by2_en  output  1  systolic array enable.
- input_array_addr_in_2by2  output  5  input mux select.
- filter_ceiling_first_array_addr_in_2by2  output  5  first-filter mux select.
- filter_ceiling_second_array_addr_in_2by2  output  5  second-filter mux select.
- buffer_read_addr_in_2by2  output  2  result-buffer read address.
- out_valid  output  1  convolution_2by2_out is valid this cycle.
- out_idx  output  2  result index tagged with out_valid (0=C11, 1=C12, 2=C21, 3=C22).

Behaviour:
- All outputs are registered.
- Reset values:
  - busy, done, acc_clr, sys_2by2_en, out_valid = 0.
  - out_idx and read address = 0.
  - All three selects = ZERO_SEL.
- States: IDLE, CLEAR, FEED, DRAIN, READ, FLUSH, DONE.
- IDLE:
  - start=1 at edge E0 latches win_row/win_col and goes to CLEAR.
  - Window inputs are ignored outside IDLE.
  - start is ignored in every non-IDLE state and is not queued.
- CLEAR (1 cycle): acc_clr=1, sys_2by2_en=0, selects=ZERO_SEL.
- FEED (N_TAPS+1 = 10 cycles, f=0..9; for tap k, r=k/3, c=k%3):
  - sys_2by2_en=1.
  - f<9: input select = 4*(win_row+r)+(win_col+c) for k=f; first-filter select = 16+f.
  - f=9: input and first-filter selects = ZERO_SEL.
  - Second-filter select is skewed by one cycle: ZERO_SEL at f=0, then 16+(f-1) for f=1..9.
- DRAIN (DRAIN_CYCLES cycles): sys_2by2_en=1, all selects = ZERO_SEL.
- READ (4 cycles): sys_2by2_en=0; read address steps 0,1,2,3.
- Buffer latency is 1 cycle:
  - out_valid=1 with out_idx=n in the cycle after read address n is driven.
  - The fourth out_valid falls in FLUSH (1 cycle).
- DONE (1 cycle): done=1, then IDLE.
- Timing with defaults:
  - acc_clr in cycle E0+1.
  - FEED in E0+2..E0+11; DRAIN in E0+12..E0+13; READ in E0+14..E0+17.
  - out_valid in E0+15..E0+18; done in E0+19.
  - busy high E0+1..E0+19.
  - Next start is accepted at the edge after done, so back-to-back job period is 20 cycles.
- abort=1 in any non-IDLE state:
  - Returns to IDLE at the next edge; done is not pulsed.
  - In the following cycle en, out_valid and acc_clr = 0, selects = ZERO_SEL, busy = 0.
  - abort in IDLE has no effect; abort has priority over start.
- Reset asserted mid-job: immediate return to reset values; no done.
- Counters are sized to hold N_TAPS and DRAIN_CYCLES; selects never exceed 25.

Optional Feature:
- Macro CONV2X2_SEQ_PERF_EN.
- When defined, adds output job_count[15:0]:
  - Increments on each done pulse.
  - Wraps from 16'hFFFF to 0.
  - Cleared by reset only; not incremented on abort.
- When not defined, the port and counter do not exist; all other behaviour is unchanged.

Test Plan:
- Reset: rst=0 mid-FEED -> all selects 25, en/busy/done/out_valid 0 while rst=0; IDLE after release.
- Job with win_row=0, win_col=0, start at E0:
  - Input selects 0,1,2,4,5,6,8,9,10,25 in FEED.
  - First-filter selects 16..24,25; second-filter selects 25,16..24.
  - out_idx 0..3 at E0+15..18; done at E0+19.
- Job with win_row=1, win_col=1 -> input selects 5,6,7,9,10,11,13,14,15,25.
- start held high continuously -> jobs start every 20 cycles; start pulses during busy are ignored (no extra done).
- abort at E0+8 -> no done, no out_valid; selects 25 at E0+9; a new start is accepted at E0+9.
- With CONV2X2_SEQ_PERF_EN: 3 completed jobs plus 1 aborted -> job_count=3. Preloaded 16'hFFFF plus one job -> 0.
